pulse_burst_scheduler: RTL and testbench
========================================

# pulse_burst_scheduler

Shares one pulse-train generator between up to REQS requesters. Each requester holds a level request. A round-robin arbiter grants one requester at a time. The granted requester receives a burst of `count` single-cycle pulses spaced `period` cycles apart, followed by a one-cycle completion strobe. The block sits between user inputs (buttons, debounced levels) and any downstream logic that consumes a paced pulse train.

## Interface
- `REQS`, default 4: number of requesters (2..8).
- `PERIOD_W`, default 8: width of the pulse-period field.
- `COUNT_W`, default 4: width of the pulses-per-burst field.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  REQS  per-requester level request; held high until `done` for that requester.
- `period`  in  PERIOD_W  pulse spacing in cycles; sampled only at grant.
- `count`  in  COUNT_W  pulses per burst; sampled only at grant.
- `grant`  out  REQS  one-hot owner of the generator; all-zero when idle.
- `pulse`  out  1  registered pulse-train output.
- `done`  out  REQS  one-cycle completion strobe to the granted requester.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, PULSE, GAP, DONE.
- IDLE → arbitration:
  - If any `req` bit is high, select the first set bit scanning upward from `last+1`, wrapping modulo REQS.
  - `last` is the index of the most recently granted requester.
  - Latch the index into `last`. Latch `period` and `count` into internal registers.
  - A latched `period` of 0 is treated as 1.
  - Next state is PULSE, or DONE if the latched `count` is 0.
- PULSE:
  - `pulse`=1 for exactly one cycle; the remaining-pulse counter decrements.
  - Next state is GAP if `period`>1; otherwise PULSE again, or DONE after the last pulse.
- GAP:
  - `pulse`=0 for `period`-1 cycles, counted by a down-counter.
  - At expiry: PULSE if pulses remain, else DONE.
  - Pulse rising edges are therefore exactly `period` cycles apart.
  - The burst lasts `count`×`period` cycles from the first pulse to DONE.
- DONE:
  - `done[last]`=1 for one cycle, with `grant` still held.
  - Next state is IDLE unconditionally.
  - A requester that keeps `req` high re-enters arbitration. It wins again only if no other request is pending.
- Abort:
  - If `req[last]` is low in any PULSE or GAP cycle, the next state is IDLE.
  - `pulse` and `grant` are 0 from the next cycle, and no `done` is issued.
  - `last` keeps the aborted index.
- Requests from non-granted requesters are ignored until IDLE; they are never queued separately.
- Changes on `period` or `count` during a burst have no effect.
- `grant` is all-zero in IDLE. It is one-hot (`1<<last`) in PULSE, GAP and DONE.
- `busy` = (state != IDLE).
- Width rules:
  - The internal period counter is PERIOD_W bits and the pulse counter is COUNT_W bits; neither counter wraps.
  - Maximum `period` is 2^PERIOD_W−1; maximum `count` is 2^COUNT_W−1.

## Timing
- Reset values: state=IDLE, `grant`=0, `pulse`=0, `done`=0, `busy`=0.
  - `last`=REQS−1, so requester 0 has first priority after reset.
- `rst` asserted mid-burst returns the block to reset values on the next edge. No `done` is issued.
- Latency: `req` sampled high in IDLE at edge t gives `grant` and `pulse` high after edge t+1. For `count`=0, `done` is high after edge t+1 instead.
- After DONE, at least one IDLE cycle occurs before the next grant, so `grant` never changes owner without an all-zero cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Simultaneous events:
  - An abort in the same cycle as the final GAP expiry takes priority: go to IDLE, no `done`.
  - `rst` overrides everything.

## Test plan
- **Single burst:** `req`=4'b0001, `period`=3, `count`=2.
  - `grant`=0001 for 7 cycles.
  - `pulse` high on cycles 1 and 4 after the request.
  - `done[0]` on cycle 7.
  - Then `grant`=0 and `busy`=0.
- **Round-robin:** `req`=4'b1111 held, `period`=1, `count`=1.
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 2 cycles and is separated by one idle cycle.
- **Degenerate config:**
  - `count`=0 → `done` one cycle after request, `pulse` never asserts.
  - `period`=0, `count`=3 → `pulse` high for 3 consecutive cycles.
- **Abort:** `period`=4, `count`=3; drop `req[2]` during the second GAP.
  - Next cycle: `grant`=0, `pulse`=0, no `done[2]`.
  - With `req[3]` pending, requester 3 is granted next.
- **Config stability:** change `period` from 2 to 5 mid-burst.
  - Pulse spacing stays 2 for the whole burst.
  - The new value applies only at the next grant.
- **Reset:** assert `rst` during PULSE.
  - All outputs are 0 the next cycle.
  - With `req`=4'b1010 after release, requester 1 is granted first.

Source files
------------

// File: rtl/pulse_burst_scheduler.sv
// pulse_burst_scheduler: round-robin shares one paced pulse-train generator
// between REQS level requesters. The owner gets `count` one-cycle pulses
// spaced `period` cycles apart, then a one-cycle done strobe.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   req     in   [REQS]     per-requester level request, held until done
//   period  in   [PERIOD_W] pulse spacing in cycles, sampled at grant (0 -> 1)
//   count   in   [COUNT_W]  pulses per burst, sampled at grant
//   grant   out  [REQS]     one-hot owner, all-zero when idle
//   pulse   out             paced pulse train
//   done    out  [REQS]     one-cycle completion strobe to the owner
//   busy    out             state is not IDLE
module pulse_burst_scheduler #(
  parameter int unsigned REQS     = 4,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned COUNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REQS-1:0]     req,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  count,
  output logic [REQS-1:0]     grant,
  output logic                pulse,
  output logic [REQS-1:0]     done,
  output logic                busy
);

  localparam int unsigned IDX_W = (REQS > 1) ? $clog2(REQS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    w_last_nxt;
  logic [IDX_W-1:0]    w_arb_idx;
  logic                w_arb_hit;
  logic                w_load;
  logic [PERIOD_W-1:0] r_per;
  logic [PERIOD_W-1:0] r_gap;
  logic [COUNT_W-1:0]  r_rem;
  logic [REQS-1:0]     w_onehot;
  logic [REQS-1:0]     r_grant;
  logic [REQS-1:0]     r_done;
  logic                r_pulse;
  logic                r_busy;

  // Round-robin pick: first set request scanning upward from last+1, wrapping
  always_comb begin
    logic [IDX_W-1:0] v_cand;
    w_arb_idx = r_last;
    w_arb_hit = 1'b0;
    v_cand    = '0;
    for (int unsigned i = 1; i <= REQS; i++) begin
      v_cand = IDX_W'((32'(r_last) + i) % REQS);
      if (!w_arb_hit && req[v_cand]) begin
        w_arb_idx = v_cand;
        w_arb_hit = 1'b1;
      end
    end
  end

  // Next-state logic; a dropped owner request aborts PULSE/GAP without done
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_arb_hit) begin
          w_last_nxt  = w_arb_idx;
          w_load      = 1'b1;
          w_state_nxt = (count == '0) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        if (!req[r_last])                  w_state_nxt = S_IDLE;
        else if (r_per > PERIOD_W'(1))     w_state_nxt = S_GAP;
        else if (r_rem == COUNT_W'(1))     w_state_nxt = S_DONE;
        else                               w_state_nxt = S_PULSE;
      end
      S_GAP: begin
        if (!req[r_last])                  w_state_nxt = S_IDLE;
        else if (r_gap == PERIOD_W'(1))    w_state_nxt = (r_rem != '0) ? S_PULSE : S_DONE;
        else                               w_state_nxt = S_GAP;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_onehot = REQS'(1) << w_last_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= IDX_W'(REQS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Burst counters; config is captured only at grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_per <= PERIOD_W'(1);
      r_gap <= '0;
      r_rem <= '0;
    end else begin
      if (w_load) begin
        r_per <= (period == '0) ? PERIOD_W'(1) : period;
        r_rem <= count;
      end else if (r_state == S_PULSE && r_rem != '0) begin
        r_rem <= r_rem - COUNT_W'(1);
      end
      // Gap counter loads on GAP entry and counts period-1 cycles down to 1
      if (w_state_nxt == S_GAP && r_state != S_GAP) begin
        r_gap <= r_per - PERIOD_W'(1);
      end else if (r_state == S_GAP && r_gap != '0) begin
        r_gap <= r_gap - PERIOD_W'(1);
      end
    end
  end

  // Outputs registered from the next state so they align with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
      r_done  <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_grant <= (w_state_nxt != S_IDLE) ? w_onehot : '0;
      r_done  <= (w_state_nxt == S_DONE) ? w_onehot : '0;
      r_pulse <= (w_state_nxt == S_PULSE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign pulse = r_pulse;
  assign busy  = r_busy;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Directed self-checking bench for pulse_burst_scheduler (REQS=4).
// Each check compares {grant, done, pulse, busy} one time unit after a rising edge.
module tb_pulse_burst_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] period;
  logic [3:0] count;
  logic [3:0] grant;
  logic       pulse;
  logic [3:0] done;
  logic       busy;

  int n_chk;
  int n_err;

  pulse_burst_scheduler #(.REQS(4), .PERIOD_W(8), .COUNT_W(4)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .period (period),
    .count  (count),
    .grant  (grant),
    .pulse  (pulse),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle and compare the packed output vector
  task automatic step_chk(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic p, input logic b);
    tick();
    chk(tag, 32'({grant, done, pulse, busy}), 32'({g, d, p, b}));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    period = 8'd0;
    count  = 4'd0;
    do_reset();
    chk("reset_outputs", 32'({grant, done, pulse, busy}), 32'd0);

    // Single burst: period 3, count 2 -> pulses on cycles 1 and 4, done on 7
    period = 8'd3; count = 4'd2; req = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      step_chk($sformatf("single_c%0d", c), 4'b0001, (c == 7) ? 4'b0001 : 4'b0000,
               (c == 1 || c == 4), 1'b1);
    end
    req = 4'b0000;
    step_chk("single_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Round-robin from reset with all requests held
    do_reset();
    period = 8'd1; count = 4'd1; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] own;
      own = 4'b0001 << (g % 4);
      step_chk($sformatf("rr%0d_pulse", g), own, 4'b0000, 1'b1, 1'b1);
      step_chk($sformatf("rr%0d_done", g), own, own, 1'b0, 1'b1);
      if (g == 4) req = 4'b0000;
      step_chk($sformatf("rr%0d_gap", g), 4'b0000, 4'b0000, 1'b0, 1'b0);
    end

    // count = 0: done on the first cycle, no pulse
    period = 8'd3; count = 4'd0; req = 4'b0001;
    step_chk("cnt0_done", 4'b0001, 4'b0001, 1'b0, 1'b1);
    req = 4'b0000;
    step_chk("cnt0_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // period = 0 behaves as 1: three back-to-back pulses
    period = 8'd0; count = 4'd3; req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      step_chk($sformatf("per0_p%0d", c), 4'b0001, 4'b0000, 1'b1, 1'b1);
    end
    step_chk("per0_done", 4'b0001, 4'b0001, 1'b0, 1'b1);
    req = 4'b0000;
    step_chk("per0_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Abort: requester 2 drops during its second gap; requester 3 then wins
    period = 8'd4; count = 4'd3; req = 4'b1100;
    for (int c = 1; c <= 6; c++) begin
      step_chk($sformatf("abort_c%0d", c), 4'b0100, 4'b0000, (c == 1 || c == 5), 1'b1);
    end
    req = 4'b1000;
    step_chk("abort_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    step_chk("abort_next_grant", 4'b1000, 4'b0000, 1'b1, 1'b1);
    req = 4'b0000;
    step_chk("abort_pulse_drop", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Config stability: period changes 2 -> 5 mid-burst, applied at next grant
    period = 8'd2; count = 4'd3; req = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      step_chk($sformatf("cfg_c%0d", c), 4'b0001, (c == 7) ? 4'b0001 : 4'b0000,
               (c == 1 || c == 3 || c == 5), 1'b1);
      if (c == 1) period = 8'd5;
    end
    req = 4'b0000;
    step_chk("cfg_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    count = 4'd1; req = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      step_chk($sformatf("cfg2_c%0d", c), 4'b0001, (c == 6) ? 4'b0001 : 4'b0000,
               (c == 1), 1'b1);
    end
    req = 4'b0000;
    step_chk("cfg2_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Reset mid-PULSE clears everything; last returns to REQS-1
    period = 8'd3; count = 4'd2; req = 4'b0001;
    step_chk("rst_pulse", 4'b0001, 4'b0000, 1'b1, 1'b1);
    rst = 1'b1; req = 4'b1010;
    step_chk("rst_clear", 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    step_chk("rst_first_grant", 4'b0010, 4'b0000, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
